control_sequencer: RTL and testbench

- Hardwired control unit for the 32-bit bus-based datapath. Generates every bus-drive, register-load, ALU-select and memory-read strobe, one T-state per clock.
- Covers instruction fetch, plus execute for register-register ALU ops, unary ops, mul/div (HI/LO) and halt.
- Replaces hand-sequenced testbench stimulus; drives the datapath control ports directly.

---
 rtl/control_pkg.sv | 83 ++++++++
 rtl/control_sequencer_reg_sel_decoder.sv | 13 +
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, T-state encoding, strobe bundle and the register one-hot helper.
package control_pkg;

    localparam int NUM_REGS  = 16;
    localparam int OP_W      = 5;
    localparam int IR_W      = 32;
    localparam int REG_IDX_W = 4;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALTED
    } state_t;

    // Execute-phase behaviour groups; every opcode maps to exactly one.
    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_UNARY, CLS_MULDIV, CLS_HALT, CLS_UNDEF
    } op_class_t;

    // Single-bit datapath strobes, registered together.
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zhi_out;
        logic zlo_out;
        logic hi_in;
        logic lo_in;
    } strobe_t;

    function automatic op_class_t classify(input logic [OP_W-1:0] opcode);
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  return CLS_ALU;
            OP_NEG, OP_NOT:                   return CLS_UNARY;
            OP_MUL, OP_DIV:                   return CLS_MULDIV;
            OP_NOP:                           return CLS_NOP;
            OP_HALT:                          return CLS_HALT;
            default:                          return CLS_UNDEF;
        endcase
    endfunction

    function automatic logic [NUM_REGS-1:0] onehot_sel(input logic [REG_IDX_W-1:0] idx,
                                                       input logic en);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (en) v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/control_sequencer_reg_sel_decoder.sv
// Register index plus enable to one-hot select for the general register file.
module reg_sel_decoder
    import control_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    // Zero when disabled, so the bus and load vectors stay one-hot or zero.
    assign onehot = onehot_sel(idx, en);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: one T-state per clock, every strobe is a
// flop loaded from the decode of the state being entered, so strobes line up
// exactly with the state register.
// Handshake: start is a level sampled only in IDLE/HALTED; mem_done is sampled
// only in T1 and ends the read wait on the edge where it is seen high.
// The fetched instruction must be present on ir by the edge that leaves T2,
// since T3 strobes are decoded from ir on that edge.
module control_sequencer
    import control_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic                mem_done,
    input  logic [IR_W-1:0]     ir,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                pc_out,
    output logic                pc_in,
    output logic                inc_pc,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                mdr_out,
    output logic                read,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                zhi_out,
    output logic                zlo_out,
    output logic                hi_in,
    output logic                lo_in,
    output logic [OP_W-1:0]     op_sel,
    output logic                run,
    output logic                illegal,
    output state_t              fsm_state
);

    state_t                state, state_nx;
    strobe_t               strb_q, strb_nx;
    logic [OP_W-1:0]       op_nx;
    logic                  run_nx, illegal_nx;
    logic [REG_IDX_W-1:0]  rin_idx, rout_idx;
    logic                  rin_en, rout_en;
    logic [NUM_REGS-1:0]   r_in_nx, r_out_nx;

    logic [OP_W-1:0]       opcode;
    logic [REG_IDX_W-1:0]  ra, rb, rc;
    op_class_t             cls;
    logic                  unused_ir_bits;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign ra     = ir[RA_MSB:RA_LSB];
    assign rb     = ir[RB_MSB:RB_LSB];
    assign rc     = ir[RC_MSB:RC_LSB];
    assign cls    = classify(opcode);
    assign unused_ir_bits = ^ir[RC_LSB-1:0];

    // Next T-state from current state, start, mem_done and the decoded opcode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_HALTED: if (start) state_nx = ST_T0;
            ST_T0:              state_nx = ST_T1;
            ST_T1:              if (mem_done) state_nx = ST_T2;
            ST_T2:              state_nx = ST_T3;
            ST_T3: begin
                case (cls)
                    CLS_ALU, CLS_UNARY, CLS_MULDIV: state_nx = ST_T4;
                    CLS_HALT:                       state_nx = ST_HALTED;
                    default:                        state_nx = ST_T0;
                endcase
            end
            ST_T4:   state_nx = (cls == CLS_ALU || cls == CLS_MULDIV) ? ST_T5 : ST_T0;
            ST_T5:   state_nx = (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
            ST_T6:   state_nx = ST_T0;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Strobe decode for the state about to be entered
    always_comb begin
        strb_nx    = '0;
        op_nx      = '0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rin_idx    = ra;
        rout_idx   = rb;
        illegal_nx = illegal;
        run_nx     = (state_nx != ST_IDLE) && (state_nx != ST_HALTED);
        case (state_nx)
            ST_T0: begin
                strb_nx.pc_out = 1'b1;
                strb_nx.mar_in = 1'b1;
                strb_nx.inc_pc = 1'b1;
                strb_nx.z_in   = 1'b1;
            end
            ST_T1: begin
                strb_nx.zlo_out = 1'b1;
                strb_nx.pc_in   = 1'b1;
                strb_nx.read    = 1'b1;
                strb_nx.mdr_in  = 1'b1;
            end
            ST_T2: begin
                strb_nx.mdr_out = 1'b1;
                strb_nx.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CLS_ALU: begin
                        rout_en      = 1'b1;
                        strb_nx.y_in = 1'b1;
                    end
                    CLS_UNARY: begin
                        rout_en      = 1'b1;
                        strb_nx.z_in = 1'b1;
                        op_nx        = opcode;
                    end
                    CLS_MULDIV: begin
                        rout_en      = 1'b1;
                        rout_idx     = ra;
                        strb_nx.y_in = 1'b1;
                    end
                    CLS_UNDEF: illegal_nx = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CLS_ALU: begin
                        rout_en      = 1'b1;
                        rout_idx     = rc;
                        strb_nx.z_in = 1'b1;
                        op_nx        = opcode;
                    end
                    CLS_MULDIV: begin
                        rout_en      = 1'b1;
                        strb_nx.z_in = 1'b1;
                        op_nx        = opcode;
                    end
                    CLS_UNARY: begin
                        strb_nx.zlo_out = 1'b1;
                        rin_en          = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                strb_nx.zlo_out = 1'b1;
                if (cls == CLS_MULDIV) strb_nx.lo_in = 1'b1;
                else                   rin_en        = 1'b1;
            end
            ST_T6: begin
                strb_nx.zhi_out = 1'b1;
                strb_nx.hi_in   = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decoder u_r_in_dec (
        .idx    (rin_idx),
        .en     (rin_en),
        .onehot (r_in_nx)
    );

    reg_sel_decoder u_r_out_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (r_out_nx)
    );

    // State and registered outputs; reset clears everything at once
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            strb_q  <= '0;
            r_in    <= '0;
            r_out   <= '0;
            op_sel  <= '0;
            run     <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            strb_q  <= strb_nx;
            r_in    <= r_in_nx;
            r_out   <= r_out_nx;
            op_sel  <= op_nx;
            run     <= run_nx;
            illegal <= illegal_nx;
        end
    end

    assign pc_out    = strb_q.pc_out;
    assign pc_in     = strb_q.pc_in;
    assign inc_pc    = strb_q.inc_pc;
    assign mar_in    = strb_q.mar_in;
    assign mdr_in    = strb_q.mdr_in;
    assign mdr_out   = strb_q.mdr_out;
    assign read      = strb_q.read;
    assign ir_in     = strb_q.ir_in;
    assign y_in      = strb_q.y_in;
    assign z_in      = strb_q.z_in;
    assign zhi_out   = strb_q.zhi_out;
    assign zlo_out   = strb_q.zlo_out;
    assign hi_in     = strb_q.hi_in;
    assign lo_in     = strb_q.lo_in;
    assign fsm_state = state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle output vectors, compared cycle by
// cycle at the falling edge.
module tb_control_sequencer;
    import control_pkg::*;

    localparam int VW = 52;  // {r_in, r_out, op_sel, strobes[13:0], run}

    localparam logic [13:0] M_PC_OUT  = 14'h0001;
    localparam logic [13:0] M_PC_IN   = 14'h0002;
    localparam logic [13:0] M_INC_PC  = 14'h0004;
    localparam logic [13:0] M_MAR_IN  = 14'h0008;
    localparam logic [13:0] M_MDR_IN  = 14'h0010;
    localparam logic [13:0] M_MDR_OUT = 14'h0020;
    localparam logic [13:0] M_READ    = 14'h0040;
    localparam logic [13:0] M_IR_IN   = 14'h0080;
    localparam logic [13:0] M_Y_IN    = 14'h0100;
    localparam logic [13:0] M_Z_IN    = 14'h0200;
    localparam logic [13:0] M_ZHI_OUT = 14'h0400;
    localparam logic [13:0] M_ZLO_OUT = 14'h0800;
    localparam logic [13:0] M_HI_IN   = 14'h1000;
    localparam logic [13:0] M_LO_IN   = 14'h2000;

    logic        clk, clr, start, mem_done;
    logic [31:0] ir;
    logic [15:0] r_in, r_out;
    logic        pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, read;
    logic        ir_in, y_in, z_in, zhi_out, zlo_out, hi_in, lo_in;
    logic [4:0]  op_sel;
    logic        run, illegal;
    state_t      fsm_state;

    logic [VW-1:0] exp_q[$];
    int            md_q[$];   // mem_done to drive in that cycle: 0, 1, or 2 = random
    string         tag_q[$];
    logic          exp_illegal;
    int            n_checks, n_fail;

    control_sequencer dut (
        .clk(clk), .clr(clr), .start(start), .mem_done(mem_done), .ir(ir),
        .r_in(r_in), .r_out(r_out), .pc_out(pc_out), .pc_in(pc_in),
        .inc_pc(inc_pc), .mar_in(mar_in), .mdr_in(mdr_in), .mdr_out(mdr_out),
        .read(read), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zhi_out(zhi_out), .zlo_out(zlo_out), .hi_in(hi_in), .lo_in(lo_in),
        .op_sel(op_sel), .run(run), .illegal(illegal), .fsm_state(fsm_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observe();
        logic [13:0] s;
        s = {lo_in, hi_in, zlo_out, zhi_out, z_in, y_in, ir_in, read,
             mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out};
        return {r_in, r_out, op_sel, s, run};
    endfunction

    task automatic push(input logic [15:0] rin, input logic [15:0] rout,
                        input logic [4:0] op, input logic [13:0] s,
                        input int md, input string tg);
        exp_q.push_back({rin, rout, op, s, 1'b1});
        md_q.push_back(md);
        tag_q.push_back(tg);
    endtask

    // Instruction-level model: fetch, then execute steps by opcode group
    task automatic build_expected(input logic [31:0] instr, input int wait_n);
        int opc, ra, rb, rc;
        logic [15:0] hra, hrb, hrc;
        logic [4:0] op5;
        op5 = instr[31:27];
        opc = int'(op5);
        ra  = int'(instr[26:23]);
        rb  = int'(instr[22:19]);
        rc  = int'(instr[18:15]);
        hra = 16'h0001 << ra;
        hrb = 16'h0001 << rb;
        hrc = 16'h0001 << rc;
        push(16'h0, 16'h0, 5'd0, M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN, 2, "T0");
        for (int k = 0; k <= wait_n; k++)
            push(16'h0, 16'h0, 5'd0, M_ZLO_OUT | M_PC_IN | M_READ | M_MDR_IN,
                 (k == wait_n) ? 1 : 0, "T1");
        push(16'h0, 16'h0, 5'd0, M_MDR_OUT | M_IR_IN, 2, "T2");
        if (opc >= 3 && opc <= 11) begin            // two-source ALU ops
            push(16'h0, hrb, 5'd0, M_Y_IN, 2, "T3");
            push(16'h0, hrc, op5, M_Z_IN, 2, "T4");
            push(hra, 16'h0, 5'd0, M_ZLO_OUT, 2, "T5");
        end else if (opc == 15 || opc == 16) begin  // MUL, DIV
            push(16'h0, hra, 5'd0, M_Y_IN, 2, "T3");
            push(16'h0, hrb, op5, M_Z_IN, 2, "T4");
            push(16'h0, 16'h0, 5'd0, M_ZLO_OUT | M_LO_IN, 2, "T5");
            push(16'h0, 16'h0, 5'd0, M_ZHI_OUT | M_HI_IN, 2, "T6");
        end else if (opc == 17 || opc == 18) begin  // NEG, NOT
            push(16'h0, hrb, op5, M_Z_IN, 2, "T3");
            push(hra, 16'h0, 5'd0, M_ZLO_OUT, 2, "T4");
        end else begin                               // NOP, HALT, undefined
            push(16'h0, 16'h0, 5'd0, 14'h0, 2, "T3");
            if (opc != 26 && opc != 27) exp_illegal = 1'b1;
        end
    endtask

    // Runs one instruction from a falling edge in T0; limit<0 runs it all
    task automatic exec_instr(input string name, input logic [31:0] instr,
                              input int wait_n, input int limit);
        logic [VW-1:0] got, want;
        int md, n;
        string tg;
        exp_q.delete(); md_q.delete(); tag_q.delete();
        ir = instr;
        build_expected(instr, wait_n);
        n = exp_q.size();
        if (limit >= 0 && limit < n) n = limit;
        for (int i = 0; i < n; i++) begin
            want = exp_q.pop_front();
            md   = md_q.pop_front();
            tg   = tag_q.pop_front();
            got  = observe();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s cyc%0d %s: got r_in=%h r_out=%h op=%b s=%b run=%b, want r_in=%h r_out=%h op=%b s=%b run=%b",
                         name, i, tg, got[51:36], got[35:20], got[19:15], got[14:1], got[0],
                         want[51:36], want[35:20], want[19:15], want[14:1], want[0]);
            end
            mem_done = (md == 2) ? 1'($urandom_range(0, 1)) : (md == 1);
            start    = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        mem_done = 1'b0;
        start    = 1'b0;
        n_checks++;
        if (illegal !== exp_illegal) begin
            n_fail++;
            $display("FAIL %s illegal: got %b want %b", name, illegal, exp_illegal);
        end
    endtask

    task automatic start_seq();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_quiet(input string name, input state_t st);
        n_checks++;
        if (observe() !== '0 || illegal !== exp_illegal || fsm_state !== st) begin
            n_fail++;
            $display("FAIL %s: got outs=%h illegal=%b state=%0d want outs=0 illegal=%b state=%0d",
                     name, observe(), illegal, fsm_state, exp_illegal, st);
        end
    endtask

    function automatic logic [31:0] rand_instr(input logic [4:0] op5);
        logic [26:0] rest;
        rest = 27'($urandom);
        return {op5, rest};
    endfunction

    task automatic test_reset();
        clr = 1'b0; start = 1'b0; mem_done = 1'b0; ir = 32'h0;
        exp_illegal = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_held", ST_IDLE);
        clr = 1'b1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("idle_wait", ST_IDLE);
        end
    endtask

    task automatic test_fetch_wait();
        start_seq();
        exec_instr("fetch_wait_nop", rand_instr(OP_NOP), 3, -1);
    endtask

    task automatic test_shl();
        exec_instr("shl", 32'h59A38000, 0, -1);
    endtask

    task automatic test_mul();
        exec_instr("mul", 32'h7A280000, 0, -1);
        exec_instr("div", rand_instr(OP_DIV), 1, -1);
    endtask

    task automatic test_unary_illegal();
        exec_instr("not", rand_instr(OP_NOT), 0, -1);
        exec_instr("neg", rand_instr(OP_NEG), 2, -1);
        exec_instr("undef", rand_instr(5'b11111), 0, -1);
        exec_instr("after_undef", rand_instr(OP_ADD), 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [4:0] op5;
        for (int i = 0; i < 40; i++) begin
            op5 = 5'($urandom_range(0, 31));
            if (op5 == OP_HALT) op5 = OP_NOP;
            exec_instr("random", rand_instr(op5), int'($urandom_range(0, 3)), -1);
        end
    endtask

    task automatic test_halt();
        exec_instr("halt", rand_instr(OP_HALT), 0, -1);
        repeat (3) begin
            check_quiet("halted", ST_HALTED);
            @(posedge clk);
            @(negedge clk);
        end
        start_seq();
        exec_instr("resume", rand_instr(OP_SUB), 0, -1);
    endtask

    task automatic test_reset_mid_t4();
        exec_instr("add_to_t4", 32'h19A38000, 0, 4);
        #1 clr = 1'b0;
        #1;
        exp_illegal = 1'b0;
        check_quiet("async_reset", ST_IDLE);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_quiet("reset_no_rin", ST_IDLE);
        end
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("post_reset_idle", ST_IDLE);
        start_seq();
        exec_instr("add_recover", 32'h19A38000, 1, -1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fetch_wait();
        test_shl();
        test_mul();
        test_unary_illegal();
        test_back_to_back();
        test_halt();
        test_reset_mid_t4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
